// File: rtl/ex_muldiv_sequencer.sv
// Iterative multiply/divide unit beside the EX ALU: shift-add multiply, restoring divide.
// Optional MULDIV_EARLY_OUT_EN: multiplies finish early once the remaining multiplier bits are zero.
module ex_muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_in,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] data_a,
  input  logic [WIDTH-1:0] data_b,
  input  logic             flush,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic [2:0]       flag
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [2:0] {S_IDLE, S_PREP, S_CALC, S_FIXUP, S_DONE} state_e;

  state_e             state_q;
  logic [1:0]         op_q;
  logic [WIDTH-1:0]   a_q, b_q;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]      cnt_q;
  logic               neg_lo_q, neg_hi_q;
  logic               busy_q, stall_q, done_q;
  logic [WIDTH-1:0]   res_lo_q, res_hi_q;
  logic [2:0]         flag_q;

  assign busy      = busy_q;
  assign stall     = stall_q;
  assign done      = done_q;
  assign result_lo = res_lo_q;
  assign result_hi = res_hi_q;
  assign flag      = flag_q;

  logic             is_div, is_signed, sa, sb, div_zero, div_ovf, early;
  logic [WIDTH-1:0] abs_a, abs_b, fix_lo, fix_hi;
  logic [WIDTH:0]   mul_sum, div_shl, div_trial;
  logic [2*WIDTH-1:0] prod;

  assign is_div    = op_q[1];
  assign is_signed = ~op_q[0];
  assign sa        = is_signed & a_q[WIDTH-1];
  assign sb        = is_signed & b_q[WIDTH-1];
  assign abs_a     = sa ? -a_q : a_q;
  assign abs_b     = sb ? -b_q : b_q;
  assign div_zero  = is_div && (b_q == '0);
  assign div_ovf   = (op_q == 2'b10) && (a_q == {1'b1, {(WIDTH-1){1'b0}}}) && (&b_q);

  // During CALC b_q holds the magnitude of the multiplicand or divisor.
  assign mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);
  assign div_shl   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign div_trial = div_shl - {1'b0, b_q};

`ifdef MULDIV_EARLY_OUT_EN
  logic [WIDTH-1:0] rem_mask;
  logic [CW:0]      shamt;
  assign rem_mask = {WIDTH{1'b1}} >> (CW'(WIDTH-1) - cnt_q);
  assign shamt    = {1'b0, cnt_q} + (CW+1)'(1);
  assign early    = !is_div && ((acc_q[WIDTH-1:0] & rem_mask) == '0);
`else
  assign early    = 1'b0;
`endif

  always_comb begin
    acc_d = '0;
    if (is_div)
      acc_d = div_trial[WIDTH] ? {div_shl[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                               : {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    else
      acc_d = {mul_sum, acc_q[WIDTH-1:1]};
`ifdef MULDIV_EARLY_OUT_EN
    if (early) acc_d = acc_q >> shamt;
`endif
  end

  always_comb begin
    prod   = neg_lo_q ? -acc_q : acc_q;
    fix_lo = prod[WIDTH-1:0];
    fix_hi = prod[2*WIDTH-1:WIDTH];
    if (is_div) begin
      fix_lo = neg_lo_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
      fix_hi = neg_hi_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      busy_q   <= 1'b0;
      stall_q  <= 1'b0;
      done_q   <= 1'b0;
      res_lo_q <= '0;
      res_hi_q <= '0;
      flag_q   <= '0;
    end else if (flush) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      stall_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (valid_in) begin
          op_q    <= op;
          a_q     <= data_a;
          b_q     <= data_b;
          state_q <= S_PREP;
          busy_q  <= 1'b1;
          stall_q <= 1'b1;
        end
        S_PREP: begin
          neg_lo_q <= sa ^ sb;
          neg_hi_q <= sa;
          cnt_q    <= CW'(WIDTH-1);
          if (div_zero) begin
            res_lo_q <= '1;
            res_hi_q <= a_q;
            flag_q   <= 3'b001;
            state_q  <= S_DONE;
            stall_q  <= 1'b0;
            done_q   <= 1'b1;
          end else if (div_ovf) begin
            res_lo_q <= a_q;
            res_hi_q <= '0;
            flag_q   <= 3'b010;
            state_q  <= S_DONE;
            stall_q  <= 1'b0;
            done_q   <= 1'b1;
          end else begin
            acc_q   <= is_div ? {{WIDTH{1'b0}}, abs_a} : {{WIDTH{1'b0}}, abs_b};
            b_q     <= is_div ? abs_b : abs_a;
            state_q <= S_CALC;
          end
        end
        S_CALC: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q - 1'b1;
          if (early || cnt_q == '0) state_q <= S_FIXUP;
        end
        S_FIXUP: begin
          res_lo_q <= fix_lo;
          res_hi_q <= fix_hi;
          flag_q   <= {(fix_lo == '0) && (fix_hi == '0), 2'b00};
          state_q  <= S_DONE;
          stall_q  <= 1'b0;
          done_q   <= 1'b1;
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ex_muldiv_sequencer.sv
// Directed bench for ex_muldiv_sequencer (default build, fixed latency).
module tb_ex_muldiv_sequencer;
  logic        clk = 1'b0;
  logic        reset, valid_in, flush;
  logic [1:0]  op;
  logic [31:0] data_a, data_b;
  logic        busy, stall, done;
  logic [31:0] result_lo, result_hi;
  logic [2:0]  flag;

  int passed = 0;
  int total  = 0;

  ex_muldiv_sequencer #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .op(op),
    .data_a(data_a), .data_b(data_b), .flush(flush),
    .busy(busy), .stall(stall), .done(done),
    .result_lo(result_lo), .result_hi(result_hi), .flag(flag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // Drive one request, accept on the next edge (k), then count cycles until done.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output bit stall_ok);
    @(negedge clk);
    valid_in = 1'b1; op = o; data_a = a; data_b = b;
    @(posedge clk);
    #1 valid_in = 1'b0;
    lat = 0; stall_ok = 1'b1;
    for (int n = 1; n <= 100; n++) begin
      @(negedge clk);
      if (done) begin
        lat = n;
        if (stall) stall_ok = 1'b0;
        break;
      end
      if (!stall) stall_ok = 1'b0;
    end
  endtask

  int lat, dn, lat2;
  bit sok, b36, b37;
  logic [31:0] lo_held;

  initial begin
    reset = 1'b1; valid_in = 1'b0; flush = 1'b0; op = '0; data_a = '0; data_b = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_stall", {31'b0, stall}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_flag", {29'b0, flag}, 32'd0);
    chk("rst_lo", result_lo, 32'd0);
    chk("rst_hi", result_hi, 32'd0);
    reset = 1'b0;

    run_op(2'b01, 32'hFFFF_FFFF, 32'h0000_0002, lat, sok);
    chk("mulu_lat", lat, 32'd35);
    chk("mulu_stall", {31'b0, sok}, 32'd1);
    chk("mulu_hi", result_hi, 32'h0000_0001);
    chk("mulu_lo", result_lo, 32'hFFFF_FFFE);
    chk("mulu_flag", {29'b0, flag}, 32'd0);

    run_op(2'b00, -32'sd3, 32'd7, lat, sok);
    chk("mul_lat", lat, 32'd35);
    chk("mul_hi", result_hi, 32'hFFFF_FFFF);
    chk("mul_lo", result_lo, 32'hFFFF_FFEB);
    chk("mul_flag", {29'b0, flag}, 32'd0);

    run_op(2'b10, -32'sd7, 32'd2, lat, sok);
    chk("div_lo", result_lo, 32'hFFFF_FFFD);
    chk("div_hi", result_hi, 32'hFFFF_FFFF);
    chk("div_flag", {29'b0, flag}, 32'd0);

    run_op(2'b11, 32'd0, 32'd5, lat, sok);
    chk("divu0_lo", result_lo, 32'd0);
    chk("divu0_hi", result_hi, 32'd0);
    chk("divu0_flag", {29'b0, flag}, 32'd4);

    run_op(2'b11, 32'd10, 32'd0, lat, sok);
    chk("dz_lat", lat, 32'd2);
    chk("dz_lo", result_lo, 32'hFFFF_FFFF);
    chk("dz_hi", result_hi, 32'h0000_000A);
    chk("dz_flag", {29'b0, flag}, 32'd1);

    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, lat, sok);
    chk("ovf_lat", lat, 32'd2);
    chk("ovf_lo", result_lo, 32'h8000_0000);
    chk("ovf_hi", result_hi, 32'd0);
    chk("ovf_flag", {29'b0, flag}, 32'd2);

    // Flush during CALC: cycle k+10 carries flush, k+11 is idle and accepts a new op.
    @(negedge clk);
    valid_in = 1'b1; op = 2'b01; data_a = 32'd5; data_b = 32'd6;
    @(posedge clk);
    #1 valid_in = 1'b0;
    dn = 0;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (done) dn++;
    end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    if (done) dn++;
    chk("fl_busy", {31'b0, busy}, 32'd0);
    chk("fl_nodone", dn, 32'd0);
    chk("fl_lo_keep", result_lo, 32'h8000_0000);
    chk("fl_flag_keep", {29'b0, flag}, 32'd2);
    valid_in = 1'b1; op = 2'b01; data_a = 32'd3; data_b = 32'd4;
    @(posedge clk);
    #1 valid_in = 1'b0;
    lat2 = 0;
    for (int n = 1; n <= 100; n++) begin
      @(negedge clk);
      if (done) begin lat2 = n + 11; break; end
    end
    chk("fl_new_lat", lat2, 32'd46);
    chk("fl_new_lo", result_lo, 32'd12);
    chk("fl_new_hi", result_hi, 32'd0);

    // flush together with valid_in in IDLE drops the request
    @(negedge clk);
    valid_in = 1'b1; flush = 1'b1;
    @(negedge clk);
    valid_in = 1'b0; flush = 1'b0;
    chk("flv_busy", {31'b0, busy}, 32'd0);

    // valid_in held high across an op: one accept per IDLE visit, then reset mid-op
    @(negedge clk);
    valid_in = 1'b1; op = 2'b01; data_a = 32'd2; data_b = 32'd3;
    @(posedge clk);
    dn = 0; lat = 0; lo_held = '0; b36 = 1'b0;
    for (int n = 1; n <= 37; n++) begin
      @(negedge clk);
      if (done) begin
        dn++;
        if (lat == 0) begin lat = n; lo_held = result_lo; end
      end
      if (n == 36) b36 = busy;
    end
    b37 = busy;
    valid_in = 1'b0;
    chk("hold_ndone", dn, 32'd1);
    chk("hold_lat", lat, 32'd35);
    chk("hold_lo", lo_held, 32'd6);
    chk("hold_idle", {31'b0, b36}, 32'd0);
    chk("hold_reacc", {31'b0, b37}, 32'd1);
    repeat (19) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("mrst_busy", {31'b0, busy}, 32'd0);
    chk("mrst_stall", {31'b0, stall}, 32'd0);
    chk("mrst_done", {31'b0, done}, 32'd0);
    chk("mrst_lo", result_lo, 32'd0);
    chk("mrst_hi", result_hi, 32'd0);
    chk("mrst_flag", {29'b0, flag}, 32'd0);
    reset = 1'b0;

    run_op(2'b11, 32'd10, 32'd0, lat, sok);
    chk("post_rst_lat", lat, 32'd2);
    chk("post_rst_hi", result_hi, 32'h0000_000A);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
